// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Main instruction decoder for the single-issue MIPS-subset datapath.
//   Decodes opcode/funct into datapath control strobes and a 3-bit ALU
//   operation. The control word is registered, so it appears one clock after
//   the instruction fields are presented. There is no combinational path from
//   the inputs to the outputs.
//
// Ports
//   clk         in   1  system clock, rising-edge active
//   rst         in   1  synchronous, active-high reset (clears the control word)
//   opcode      in   6  instruction bits [31:26]
//   funct       in   6  instruction bits [5:0], used only for R-type
//   ALUSrc      out  1  ALU operand B = sign-extended immediate (else rt)
//   RegDst      out  1  write register = rd (else rt)
//   MemWrite    out  1  data-memory write strobe
//   MemRead     out  1  data-memory read strobe
//   Beq         out  1  branch-if-equal request
//   Bne         out  1  branch-if-not-equal request
//   Jump        out  1  unconditional jump request
//   MemToReg    out  1  register write data from memory (else from ALU)
//   RegWrite    out  1  register-file write enable
//   ALUControl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
// -----------------------------------------------------------------------------
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       ALUSrc,
  output logic       RegDst,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       Beq,
  output logic       Bne,
  output logic       Jump,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic [2:0] ALUControl
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       alu_src;
    logic       reg_dst;
    logic       mem_write;
    logic       mem_read;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       mem_to_reg;
    logic       reg_write;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl_q;

  // Combinational decode. Anything not recognised falls through as a NOP
  // (all zeros), which guarantees no write and no control transfer.
  always_comb begin
    // NOTE: default the whole word first so every path assigns every bit;
    // otherwise unlisted cases would infer latches.
    dec = '0;
    unique case (opcode)
      OP_RTYPE: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        unique case (funct)
          FN_ADD:  dec.alu_ctrl = ALU_ADD;
          FN_SUB:  dec.alu_ctrl = ALU_SUB;
          FN_AND:  dec.alu_ctrl = ALU_AND;
          FN_OR:   dec.alu_ctrl = ALU_OR;
          FN_SLT:  dec.alu_ctrl = ALU_SLT;
          default: dec          = '0;  // unsupported funct -> NOP
        endcase
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        dec.beq      = 1'b1;
        dec.alu_ctrl = ALU_SUB;
      end
      OP_BNE: begin
        dec.bne      = 1'b1;
        dec.alu_ctrl = ALU_SUB;
      end
      OP_J: begin
        dec.jump     = 1'b1;
        dec.alu_ctrl = ALU_AND;
      end
      default: dec = '0;
    endcase
  end

  // Registered control word; reset takes priority over the decode.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= dec;
  end

  assign ALUSrc     = ctrl_q.alu_src;
  assign RegDst     = ctrl_q.reg_dst;
  assign MemWrite   = ctrl_q.mem_write;
  assign MemRead    = ctrl_q.mem_read;
  assign Beq        = ctrl_q.beq;
  assign Bne        = ctrl_q.bne;
  assign Jump       = ctrl_q.jump;
  assign MemToReg   = ctrl_q.mem_to_reg;
  assign RegWrite   = ctrl_q.reg_write;
  assign ALUControl = ctrl_q.alu_ctrl;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Self-checking bench for control_unit. Observed outputs are packed as
//   {ALUSrc,RegDst,MemWrite,MemRead,Beq,Bne,Jump,MemToReg,RegWrite,ALUControl}.
//   Directed vectors carry hand-written expected words; random stimulus is
//   checked against a lookup-table model of the instruction set.
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ALUSrc, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite;
  logic [2:0] ALUControl;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .ALUSrc     (ALUSrc),
    .RegDst     (RegDst),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Beq        (Beq),
    .Bne        (Bne),
    .Jump       (Jump),
    .MemToReg   (MemToReg),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] observed();
    return {ALUSrc, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite, ALUControl};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (op=%b funct=%b)", name, act, exp, opcode, funct);
    end
  endtask

  // Reference model: a list of supported instructions, searched linearly.
  // Entries with use_fn=0 match on opcode alone. No match means NOP.
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    bit          use_fn;
    logic [11:0] word;
  } isa_t;

  isa_t isa [10];

  initial begin
    //                              A R M M B B J M R ALU
    //                              S D W R e n m 2 W
    isa[0] = '{6'b000000, 6'b100000, 1'b1, 12'b0_1_0_0_0_0_0_0_1_010};  // add
    isa[1] = '{6'b000000, 6'b100010, 1'b1, 12'b0_1_0_0_0_0_0_0_1_110};  // sub
    isa[2] = '{6'b000000, 6'b100100, 1'b1, 12'b0_1_0_0_0_0_0_0_1_000};  // and
    isa[3] = '{6'b000000, 6'b100101, 1'b1, 12'b0_1_0_0_0_0_0_0_1_001};  // or
    isa[4] = '{6'b000000, 6'b101010, 1'b1, 12'b0_1_0_0_0_0_0_0_1_111};  // slt
    isa[5] = '{6'b100011, 6'b000000, 1'b0, 12'b1_0_0_1_0_0_0_1_1_010};  // lw
    isa[6] = '{6'b101011, 6'b000000, 1'b0, 12'b1_0_1_0_0_0_0_0_0_010};  // sw
    isa[7] = '{6'b000100, 6'b000000, 1'b0, 12'b0_0_0_0_1_0_0_0_0_110};  // beq
    isa[8] = '{6'b000101, 6'b000000, 1'b0, 12'b0_0_0_0_0_1_0_0_0_110};  // bne
    isa[9] = '{6'b000010, 6'b000000, 1'b0, 12'b0_0_0_0_0_0_1_0_0_000};  // j
  end

  function automatic logic [11:0] model(input logic [5:0] op, input logic [5:0] fn);
    foreach (isa[i])
      if (isa[i].op == op && (!isa[i].use_fn || isa[i].fn == fn)) return isa[i].word;
    return 12'b0;
  endfunction

  // Apply inputs, then sample just after the next rising edge.
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn);
    rst    = r;
    opcode = op;
    funct  = fn;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [11:0] exp;
  } vec_t;

  localparam logic [11:0] W_LW  = 12'b1_0_0_1_0_0_0_1_1_010;
  localparam logic [11:0] W_SW  = 12'b1_0_1_0_0_0_0_0_0_010;
  localparam logic [11:0] W_BEQ = 12'b0_0_0_0_1_0_0_0_0_110;
  localparam logic [11:0] W_J   = 12'b0_0_0_0_0_0_1_0_0_000;
  localparam logic [11:0] W_ADD = 12'b0_1_0_0_0_0_0_0_1_010;

  initial begin
    vec_t vecs [14];
    logic [5:0] ops [7];
    logic [11:0] exp_w, got;

    vecs[0]  = '{"r_add",     6'b000000, 6'b100000, W_ADD};
    vecs[1]  = '{"r_sub",     6'b000000, 6'b100010, 12'b0_1_0_0_0_0_0_0_1_110};
    vecs[2]  = '{"r_and",     6'b000000, 6'b100100, 12'b0_1_0_0_0_0_0_0_1_000};
    vecs[3]  = '{"r_or",      6'b000000, 6'b100101, 12'b0_1_0_0_0_0_0_0_1_001};
    vecs[4]  = '{"r_slt",     6'b000000, 6'b101010, 12'b0_1_0_0_0_0_0_0_1_111};
    vecs[5]  = '{"lw",        6'b100011, 6'b010101, W_LW};
    vecs[6]  = '{"sw",        6'b101011, 6'b100000, W_SW};
    vecs[7]  = '{"beq",       6'b000100, 6'b000000, W_BEQ};
    vecs[8]  = '{"bne",       6'b000101, 6'b101010, 12'b0_0_0_0_0_1_0_0_0_110};
    vecs[9]  = '{"j",         6'b000010, 6'b100010, W_J};
    vecs[10] = '{"nop_fn3f",  6'b000000, 6'b111111, 12'b0};
    vecs[11] = '{"nop_op3f",  6'b111111, 6'b100000, 12'b0};
    vecs[12] = '{"nop_fn21",  6'b000000, 6'b100001, 12'b0};
    vecs[13] = '{"nop_op01",  6'b000001, 6'b000000, 12'b0};

    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b111111};

    // Reset held for two edges with lw presented; then release.
    step(1'b1, 6'b100011, 6'b000000);
    check("reset_edge1", observed(), 12'b0);
    step(1'b1, 6'b100011, 6'b000000);
    check("reset_edge2", observed(), 12'b0);
    step(1'b0, 6'b100011, 6'b000000);
    check("reset_release_lw", observed(), W_LW);

    // Directed decode table.
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].op, vecs[i].fn);
      check(vecs[i].name, observed(), vecs[i].exp);
    end

    // Holding lw with random funct must not change the word.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 6'b100011, 6'($urandom));
      check("lw_hold", observed(), W_LW);
    end

    // Mid-cycle input changes are invisible until the next edge.
    step(1'b0, 6'b101011, 6'b000000);
    check("mid_pre_sw", observed(), W_SW);
    opcode = 6'b000100;
    #2;
    check("mid_hold_1", observed(), W_SW);
    opcode = 6'b000010;
    funct  = 6'b101010;
    #1;
    check("mid_hold_2", observed(), W_SW);
    @(posedge clk);
    #1;
    check("mid_after_edge_j", observed(), W_J);

    // Reset asserted mid-stream overrides a valid decode.
    step(1'b0, 6'b000000, 6'b100000);
    check("stream_add", observed(), W_ADD);
    step(1'b1, 6'b000000, 6'b100000);
    check("stream_reset", observed(), 12'b0);
    step(1'b0, 6'b000100, 6'b000000);
    check("stream_resume_beq", observed(), W_BEQ);

    // Randomized stimulus against the lookup model, plus invariants.
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 1) == 0) ? 6'($urandom) : vecs[$urandom_range(0, 4)].fn;
      exp_w = model(op, fn);
      step(1'b0, op, fn);
      got = observed();
      check("random", got, exp_w);
      check("inv_one_xfer", 12'($countones({Beq, Bne, Jump}) <= 1), 12'd1);
      check("inv_rd_wr", 12'(!(MemRead && MemWrite) && !(RegWrite && MemWrite)), 12'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
